formula_2_pipe: RTL and testbench
=================================

Name: formula_2_pipe

Overview:
- Fully pipelined evaluator of res = isqrt(a + isqrt(b + isqrt(c))) on 32-bit unsigned arguments.
- Accepts one argument set per clock with no back-pressure.
- Built from three chained instances of the team's existing pipelined isqrt block, plus valid-tagged delay lines that align b and a with the partial results.
- Sits in the arithmetic/pipelining layer and feeds downstream consumers through a simple valid strobe.

Parameters:
- isqrt_latency, 16, pipeline depth in cycles of each isqrt instance (x_vld to y_vld); must match the isqrt block's stage count.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous reset, active-low (rst == 0 resets on the next rising clk edge)
- arg_vld  input  1  a, b, c valid this cycle
- a  input  32  unsigned argument
- b  input  32  unsigned argument
- c  input  32  unsigned argument
- res_vld  output  1  res valid this cycle
- res  output  32  unsigned result; bits [31:16] always 0

Behaviour:
- Stage 1: isqrt #1 gets x = c, x_vld = arg_vld. In parallel, b enters a delay line of depth isqrt_latency, tagged with arg_vld.
- Stage 2: sum2 = delayed_b + {16'b0, isqrt1.y}, combinational, 32-bit wrap-around (carry discarded). isqrt #2 gets x = sum2, x_vld = isqrt1.y_vld.
- a enters a delay line of depth 2*isqrt_latency. The two delay lines may be chained: a delayed by L, then by L again.
- Stage 3: sum3 = delayed_a + {16'b0, isqrt2.y}, 32-bit wrap-around. isqrt #3 gets x = sum3, x_vld = isqrt2.y_vld.
- res_vld = isqrt3.y_vld.
- res = res_vld ? {16'b0, isqrt3.y} : 32'b0.
- Latency: exactly 3*isqrt_latency cycles from arg_vld to res_vld (48 by default). There are no extra registers around the adders.
- Throughput: one result per cycle. Results emerge in input order. The arg_vld gap pattern is reproduced exactly on res_vld.
- Arguments presented while arg_vld = 0 are ignored and produce no result.
- Delay-line valid bits and isqrt valid bits alias-check nothing: the timing alignment is structural, not handshaked.
- Reset values: every valid bit in the delay lines and isqrt instances is cleared, so res_vld = 0 and res = 0 from the first cycle after a reset edge. Data registers need not be reset.
- Reset mid-operation: all in-flight results are discarded and never appear. The first post-reset result corresponds to the first arg_vld = 1 sampled with rst = 1, and appears 3*isqrt_latency cycles later.
- Simultaneous arg_vld = 1 and rst = 0: reset wins; the argument is dropped.

Decomposition:
- Shared package: width constants arg_width = 32 and root_width = 16; optional default latency constant.
- Natural sub-module: shift_register_with_valid #(width, depth).
  - Ports: clk, rst, in_vld, in_data[width], out_vld, out_data[width].
  - out = in delayed exactly depth cycles; valid bits reset to 0 on synchronous active-low rst.
  - Instantiated for b (width 32, depth L) and for a (width 32, depth 2L).
- isqrt is reused unchanged, three instances.

Test Plan:
- Reset then single vector a=9, b=12, c=16: isqrt(16)=4, 12+4=16 → 4, 9+4=13 → 3. Required: res=3 with res_vld high exactly 48 cycles after arg_vld, and res=0 / res_vld=0 on all other cycles.
- Zero vector and saturation. a=b=c=0 → res=0. c=0xFFFFFFFF, b=0, a=0xFFFFFFFF: isqrt(c)=65535; 0+65535 → 255; a+255 wraps to 254 → res=15.
- Back-to-back burst of 200 random vectors with arg_vld high every cycle → 200 results, in order, matching the software model, with res_vld contiguous for 200 cycles.
- Random arg_vld gaps (about 50% duty): the res_vld pattern equals the arg_vld pattern shifted by 48 cycles, and every value matches the model.
- Drive rst=0 for 2 cycles while 20 results are in flight → none of them appear. A vector issued after reset (a=0, b=0, c=81 → isqrt(81)=9 → 3 → res=1) appears at +48.
- Standalone shift_register_with_valid at (width 8, depth 8) and (width 17, depth 13), with random data and valid → each output equals the input delayed by exactly depth cycles; out_vld=0 after reset.

Source files
------------

// File: rtl/formula_2_pipe_pkg.sv
// rtl/formula_2_pipe_pkg.sv - shared widths and isqrt step helpers for formula_2_pipe
package formula_2_pipe_pkg;

  localparam int arg_width             = 32;
  localparam int root_width            = 16;
  localparam int default_isqrt_latency = 16;

  // One digit-by-digit square root step: returns {op_next, res_next}.
  function automatic logic [2*arg_width-1:0] isqrt_step(
    input logic [arg_width-1:0] op,
    input logic [arg_width-1:0] res,
    input int                   stage
  );
    logic [arg_width:0]   one;
    logic [arg_width:0]   trial;
    logic [arg_width-1:0] op_n;
    logic [arg_width-1:0] res_n;
    one   = {{arg_width{1'b0}}, 1'b1} << (arg_width - 2 - 2 * stage);
    trial = {1'b0, res} + one;
    if ({1'b0, op} >= trial) begin
      op_n  = op - trial[arg_width-1:0];
      res_n = arg_width'(({1'b0, res} >> 1) + one);
    end else begin
      op_n  = op;
      res_n = res >> 1;
    end
    return {op_n, res_n};
  endfunction

  // Final step only needs the root bit, the remainder is discarded.
  function automatic logic [root_width-1:0] isqrt_last(
    input logic [arg_width-1:0] op,
    input logic [arg_width-1:0] res
  );
    logic fit;
    fit = ({1'b0, op} >= ({1'b0, res} + {{arg_width{1'b0}}, 1'b1}));
    return root_width'((res >> 1) + {{(arg_width-1){1'b0}}, fit});
  endfunction

endpackage

// File: rtl/isqrt.sv
// rtl/isqrt.sv - fully pipelined 32-bit integer square root, one root bit per stage
module isqrt
  import formula_2_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  x_vld,
  input  logic [arg_width-1:0]  x,
  output logic                  y_vld,
  output logic [root_width-1:0] y
);

  localparam int stages = root_width;

  logic [stages-1:0]                vld_q, vld_d;
  logic [stages-2:0][arg_width-1:0] op_q, op_d;
  logic [stages-2:0][arg_width-1:0] res_q, res_d;
  logic [root_width-1:0]            y_q, y_d;

  always_comb begin
    vld_d              = {vld_q[stages-2:0], x_vld};
    op_d               = '0;
    res_d              = '0;
    {op_d[0], res_d[0]} = isqrt_step(x, '0, 0);
    for (int s = 1; s < stages - 1; s++) begin
      {op_d[s], res_d[s]} = isqrt_step(op_q[s-1], res_q[s-1], s);
    end
    y_d = isqrt_last(op_q[stages-2], res_q[stages-2]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
    op_q  <= op_d;
    res_q <= res_d;
    y_q   <= y_d;
  end

  assign y_vld = vld_q[stages-1];
  assign y     = y_q;

endmodule

// File: rtl/shift_register_with_valid.sv
// rtl/shift_register_with_valid.sv - fixed-depth data delay line with a resettable valid tag
module shift_register_with_valid #(
  parameter int width = 32,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [width-1:0] in_data,
  output logic             out_vld,
  output logic [width-1:0] out_data
);

  logic [depth-1:0]            vld_q, vld_d;
  logic [depth-1:0][width-1:0] data_q, data_d;

  always_comb begin
    vld_d     = '0;
    data_d    = '0;
    vld_d[0]  = in_vld;
    data_d[0] = in_data;
    for (int i = 1; i < depth; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
    data_q <= data_d;
  end

  assign out_vld  = vld_q[depth-1];
  assign out_data = data_q[depth-1];

endmodule

// File: rtl/formula_2_pipe.sv
// rtl/formula_2_pipe.sv - pipelined res = isqrt(a + isqrt(b + isqrt(c))), one set per clock
module formula_2_pipe
  import formula_2_pipe_pkg::*;
#(
  parameter int isqrt_latency = default_isqrt_latency
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arg_vld,
  input  logic [arg_width-1:0] a,
  input  logic [arg_width-1:0] b,
  input  logic [arg_width-1:0] c,
  output logic                 res_vld,
  output logic [arg_width-1:0] res
);

  logic                  b_dly_vld, a_dly_vld;
  logic [arg_width-1:0]  b_dly, a_dly;
  logic                  y1_vld, y2_vld, y3_vld;
  logic [root_width-1:0] y1, y2, y3;
  logic [arg_width-1:0]  sum2, sum3;
  logic                  x2_vld, x3_vld;

  shift_register_with_valid #(.width(arg_width), .depth(isqrt_latency)) u_b_dly (
    .clk(clk), .rst(rst), .in_vld(arg_vld), .in_data(b),
    .out_vld(b_dly_vld), .out_data(b_dly)
  );

  shift_register_with_valid #(.width(arg_width), .depth(2 * isqrt_latency)) u_a_dly (
    .clk(clk), .rst(rst), .in_vld(arg_vld), .in_data(a),
    .out_vld(a_dly_vld), .out_data(a_dly)
  );

  isqrt u_isqrt1 (.clk(clk), .rst(rst), .x_vld(arg_vld), .x(c),    .y_vld(y1_vld), .y(y1));
  isqrt u_isqrt2 (.clk(clk), .rst(rst), .x_vld(x2_vld),  .x(sum2), .y_vld(y2_vld), .y(y2));
  isqrt u_isqrt3 (.clk(clk), .rst(rst), .x_vld(x3_vld),  .x(sum3), .y_vld(y3_vld), .y(y3));

  // Delay-line tags equal the isqrt tags by construction, so ANDing them changes nothing.
  always_comb begin
    sum2    = b_dly + {{(arg_width-root_width){1'b0}}, y1};
    sum3    = a_dly + {{(arg_width-root_width){1'b0}}, y2};
    x2_vld  = y1_vld & b_dly_vld;
    x3_vld  = y2_vld & a_dly_vld;
    res_vld = y3_vld;
    res     = y3_vld ? {{(arg_width-root_width){1'b0}}, y3} : '0;
  end

endmodule

// File: tb/tb_formula_2_pipe.sv
// tb/tb_formula_2_pipe.sv - randomized self-checking bench for formula_2_pipe and its delay line
module tb_formula_2_pipe;

  localparam int lat = 48;

  logic        clk = 1'b0;
  logic        rst;
  logic        arg_vld;
  logic [31:0] a, b, c;
  logic        res_vld;
  logic [31:0] res;

  logic        s8_iv, s8_ov;
  logic [7:0]  s8_id, s8_od;
  logic        s17_iv, s17_ov;
  logic [16:0] s17_id, s17_od;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic        vld;
    logic [31:0] val;
  } ent_t;

  ent_t q_res[$];
  ent_t q_s8[$];
  ent_t q_s17[$];

  always #5 clk = ~clk;

  formula_2_pipe dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .a(a), .b(b), .c(c),
    .res_vld(res_vld), .res(res)
  );

  shift_register_with_valid #(.width(8), .depth(8)) u_s8 (
    .clk(clk), .rst(rst), .in_vld(s8_iv), .in_data(s8_id),
    .out_vld(s8_ov), .out_data(s8_od)
  );

  shift_register_with_valid #(.width(17), .depth(13)) u_s17 (
    .clk(clk), .rst(rst), .in_vld(s17_iv), .in_data(s17_id),
    .out_vld(s17_ov), .out_data(s17_od)
  );

  function automatic logic [31:0] isq(input logic [31:0] x);
    longint unsigned r, xx;
    xx = longint'(x);
    r  = longint'($sqrt(real'(xx)));
    while (r * r > xx) r--;
    while ((r + 1) * (r + 1) <= xx) r++;
    return 32'(r);
  endfunction

  function automatic logic [31:0] formula(input logic [31:0] fa, input logic [31:0] fb,
                                          input logic [31:0] fc);
    logic [31:0] s2, s3;
    s2 = fb + isq(fc);
    s3 = fa + isq(s2);
    return isq(s3);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [31:0] ic, input logic r, input logic use_exp,
                      input logic [31:0] ev);
    ent_t e, e8, e17;
    rst     = r;
    arg_vld = v;
    a       = ia;
    b       = ib;
    c       = ic;
    s8_iv   = 1'($urandom_range(0, 1));
    s8_id   = 8'($urandom);
    s17_iv  = 1'($urandom_range(0, 1));
    s17_id  = 17'($urandom);
    e.vld   = v & r;
    e.val   = e.vld ? (use_exp ? ev : formula(ia, ib, ic)) : 32'd0;
    e8.vld  = s8_iv & r;
    e8.val  = 32'(s8_id);
    e17.vld = s17_iv & r;
    e17.val = 32'(s17_id);
    q_res.push_back(e);
    q_s8.push_back(e8);
    q_s17.push_back(e17);
    @(posedge clk);
    #1;
    cyc++;
    if (!r) begin
      foreach (q_res[i]) q_res[i] = '0;
      foreach (q_s8[i])  q_s8[i]  = '0;
      foreach (q_s17[i]) q_s17[i] = '0;
    end
    e = q_res.pop_front();
    check("res_vld", 32'(res_vld), 32'(e.vld));
    check("res", res, e.val);
    e8 = q_s8.pop_front();
    check("s8_vld", 32'(s8_ov), 32'(e8.vld));
    if (e8.vld) check("s8_data", 32'(s8_od), e8.val);
    e17 = q_s17.pop_front();
    check("s17_vld", 32'(s17_ov), 32'(e17.vld));
    if (e17.vld) check("s17_data", 32'(s17_od), e17.val);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, $urandom, 1'b1, 1'b0, 32'd0);
  endtask

  initial begin
    rst     = 1'b0;
    arg_vld = 1'b0;
    a       = '0;
    b       = '0;
    c       = '0;
    s8_iv   = 1'b0;
    s8_id   = '0;
    s17_iv  = 1'b0;
    s17_id  = '0;
    for (int i = 0; i < lat - 1; i++) q_res.push_back('0);
    for (int i = 0; i < 8 - 1; i++)   q_s8.push_back('0);
    for (int i = 0; i < 13 - 1; i++)  q_s17.push_back('0);

    repeat (3) step(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b0, 32'd0);
    idle(4);

    step(1'b1, 32'd9, 32'd12, 32'd16, 1'b1, 1'b1, 32'd3);
    idle(52);

    step(1'b1, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0);
    step(1'b1, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd15);
    idle(50);

    repeat (200) step(1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0, 32'd0);
    idle(50);

    repeat (300) step(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 1'b1, 1'b0, 32'd0);
    repeat (60) step(1'($urandom_range(0, 1)), $urandom_range(0, 5000), $urandom_range(0, 5000),
                     $urandom_range(0, 100000), 1'b1, 1'b0, 32'd0);
    idle(50);

    repeat (20) step(1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0, 32'd0);
    repeat (2) step(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b0, 32'd0);
    step(1'b1, 32'd0, 32'd0, 32'd81, 1'b1, 1'b1, 32'd1);
    idle(55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
